// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive deframer.
//   deframe_state_t : deframer FSM states
//   pl_beat_t       : one payload beat (byte + end-of-frame marker)
//   SOF_BYTE        : start-of-frame marker
//   CRC8_POLY       : CRC-8 polynomial used when UART_DEFRAME_CRC8_EN is defined
//   crc8_update     : MSB-first CRC-8 step over one byte (init/xorout handled by caller)
package uart_pkg;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHK,
    ST_DRAIN
  } deframe_state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } pl_beat_t;

  localparam logic [7:0] SOF_BYTE  = 8'h7E;
  localparam logic [7:0] CRC8_POLY = 8'h07;

  // Non-reflected CRC-8, one byte per call.
  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/uart_rx_deframer_if.sv
// Payload stream between the deframer and its consumer.
//   o_pl_data  : payload byte
//   o_pl_valid : byte valid, held until accepted
//   o_pl_last  : final payload byte of the frame
//   i_pl_ready : consumer accepts when valid & ready
interface uart_rx_deframer_if;
  logic [7:0] o_pl_data;
  logic       o_pl_valid;
  logic       o_pl_last;
  logic       i_pl_ready;

  modport master (output o_pl_data, output o_pl_valid, output o_pl_last, input i_pl_ready);
  modport slave  (input o_pl_data, input o_pl_valid, input o_pl_last, output i_pl_ready);
endinterface

// File: rtl/uart_deframe_buf.sv
// Payload buffer: DEPTH x 8 simple dual-port RAM, synchronous write, registered read.
//   i_clk              : clock
//   i_wr_en/addr/data  : write port
//   i_rd_en/addr       : read request; data appears on o_rd_data the next cycle
//   o_rd_data          : registered read data (holds while i_rd_en is low)
module uart_deframe_buf #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic          i_clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [7:0]    i_wr_data,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [7:0]    o_rd_data
);

  logic [7:0] mem_q [DEPTH];

  // Storage has no reset; contents are always written before they are read.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) mem_q[i_wr_addr] <= i_wr_data;
    if (i_rd_en) o_rd_data <= mem_q[i_rd_addr];
  end

endmodule

// File: rtl/uart_rx_deframer.sv
// Framed-packet extractor behind the UART byte receiver.
// Frame: SOF 0x7E, LEN (1..MAX_LEN), LEN payload bytes, check byte. Payload is
// buffered and only streamed out after the check byte matches.
// Build option: UART_DEFRAME_CRC8_EN selects CRC-8 (poly 0x07, init 0) over
// LEN+payload; otherwise the check byte makes LEN+payload+chk == 0 mod 256.
// Ports:
//   i_clk, i_rst_n      : clock, async active-low reset
//   i_rx_data/ready     : receiver byte and level ready flag (rising edge = new byte)
//   pl                  : payload stream (master side)
//   o_frame_ok          : pulse, check matched
//   o_err_chk           : pulse, check mismatch, frame dropped
//   o_err_len           : pulse, LEN out of range
//   o_err_timeout       : pulse, inter-byte timeout mid-frame
//   o_overrun           : pulse per byte dropped while draining
//   o_busy              : high outside HUNT
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int unsigned MAX_LEN      = 64,
  parameter int unsigned TIMEOUT_CLKS = 100000
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [7:0]                i_rx_data,
  input  logic                      i_rx_ready,
  uart_rx_deframer_if.master        pl,
  output logic                      o_frame_ok,
  output logic                      o_err_chk,
  output logic                      o_err_len,
  output logic                      o_err_timeout,
  output logic                      o_overrun,
  output logic                      o_busy
);

  localparam int unsigned AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TW        = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CLKS - 1);
  localparam logic [7:0] MAX_LEN_B  = 8'(MAX_LEN);

  deframe_state_t state_q, state_d;
  logic           ready_q;
  logic [7:0]     len_q, len_d;
  logic [7:0]     idx_q, idx_d;
  logic [7:0]     rd_ptr_q, rd_ptr_d;
  logic [7:0]     acc_q, acc_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           pend_q, pend_d;
  logic           pend_last_q, pend_last_d;
  pl_beat_t       out_q, out_d;
  logic           valid_q, valid_d;
  logic           frame_ok_q, frame_ok_d;
  logic           err_chk_q, err_chk_d;
  logic           err_len_q, err_len_d;
  logic           err_to_q, err_to_d;
  logic           overrun_q, overrun_d;
  logic           busy_q, busy_d;

  logic           rx_stb, hs, load, tmo_hit;
  logic           wr_en, rd_en;
  logic [AW-1:0]  wr_addr, rd_addr;
  logic [7:0]     rd_data;

  // Running check value, one byte per strobe.
  function automatic logic [7:0] chk_step(input logic [7:0] acc, input logic [7:0] b);
`ifdef UART_DEFRAME_CRC8_EN
    return crc8_update(acc, b);
`else
    return 8'(acc + b);
`endif
  endfunction

  function automatic logic chk_match(input logic [7:0] acc, input logic [7:0] b);
`ifdef UART_DEFRAME_CRC8_EN
    return acc == b;
`else
    return 8'(acc + b) == 8'h00;
`endif
  endfunction

  uart_deframe_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
    .i_clk     (i_clk),
    .i_wr_en   (wr_en),
    .i_wr_addr (wr_addr),
    .i_wr_data (i_rx_data),
    .i_rd_en   (rd_en),
    .i_rd_addr (rd_addr),
    .o_rd_data (rd_data)
  );

  assign rx_stb  = i_rx_ready & ~ready_q;
  assign hs      = valid_q & pl.i_pl_ready;
  assign tmo_hit = (tmo_q == TO_LAST);

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    rd_ptr_d    = rd_ptr_q;
    acc_d       = acc_q;
    pend_d      = pend_q;
    pend_last_d = pend_last_q;
    out_d       = out_q;
    valid_d     = valid_q;
    frame_ok_d  = 1'b0;
    err_chk_d   = 1'b0;
    err_len_d   = 1'b0;
    err_to_d    = 1'b0;
    overrun_d   = 1'b0;
    wr_en       = 1'b0;
    wr_addr     = AW'(idx_q);
    rd_en       = 1'b0;
    rd_addr     = AW'(rd_ptr_q);
    load        = 1'b0;

    unique case (state_q)
      ST_HUNT: begin
        if (rx_stb && i_rx_data == SOF_BYTE) state_d = ST_LEN;
      end
      ST_LEN: begin
        if (rx_stb) begin
          len_d = i_rx_data;
          acc_d = chk_step(8'h00, i_rx_data);
          idx_d = 8'd0;
          if (i_rx_data == 8'd0 || i_rx_data > MAX_LEN_B) begin
            err_len_d = 1'b1;
            state_d   = ST_HUNT;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end else if (tmo_hit) begin
          err_to_d = 1'b1;
          state_d  = ST_HUNT;
        end
      end
      ST_PAYLOAD: begin
        if (rx_stb) begin
          wr_en = 1'b1;
          acc_d = chk_step(acc_q, i_rx_data);
          idx_d = idx_q + 8'd1;
          if (idx_q == len_q - 8'd1) state_d = ST_CHK;
        end else if (tmo_hit) begin
          err_to_d = 1'b1;
          state_d  = ST_HUNT;
        end
      end
      ST_CHK: begin
        if (rx_stb) begin
          if (chk_match(acc_q, i_rx_data)) begin
            // Prefetch byte 0 now so valid rises two cycles after this strobe.
            frame_ok_d  = 1'b1;
            state_d     = ST_DRAIN;
            rd_en       = 1'b1;
            rd_addr     = '0;
            rd_ptr_d    = 8'd1;
            pend_d      = 1'b1;
            pend_last_d = (len_q == 8'd1);
          end else begin
            err_chk_d = 1'b1;
            state_d   = ST_HUNT;
          end
        end else if (tmo_hit) begin
          err_to_d = 1'b1;
          state_d  = ST_HUNT;
        end
      end
      ST_DRAIN: begin
        if (rx_stb) overrun_d = 1'b1;
        if (hs) begin
          valid_d = 1'b0;
          if (out_q.last) state_d = ST_HUNT;
        end
        // RAM output register acts as the skid slot behind the output register.
        load = pend_q & (~valid_q | hs);
        if (load) begin
          out_d   = '{data: rd_data, last: pend_last_q};
          valid_d = 1'b1;
          pend_d  = 1'b0;
        end
        if (rd_ptr_q < len_q && (!pend_q || load)) begin
          rd_en       = 1'b1;
          rd_ptr_d    = rd_ptr_q + 8'd1;
          pend_d      = 1'b1;
          pend_last_d = (rd_ptr_q == len_q - 8'd1);
        end
      end
      default: state_d = ST_HUNT;
    endcase

    // Timeout runs only while a frame is being collected; any strobe restarts it.
    if (rx_stb || !(state_d inside {ST_LEN, ST_PAYLOAD, ST_CHK})) tmo_d = '0;
    else                                                          tmo_d = tmo_q + TW'(1);

    busy_d = (state_d != ST_HUNT);
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_HUNT;
      ready_q     <= 1'b1;
      len_q       <= '0;
      idx_q       <= '0;
      rd_ptr_q    <= '0;
      acc_q       <= '0;
      tmo_q       <= '0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      out_q       <= '0;
      valid_q     <= 1'b0;
      frame_ok_q  <= 1'b0;
      err_chk_q   <= 1'b0;
      err_len_q   <= 1'b0;
      err_to_q    <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= i_rx_ready;
      len_q       <= len_d;
      idx_q       <= idx_d;
      rd_ptr_q    <= rd_ptr_d;
      acc_q       <= acc_d;
      tmo_q       <= tmo_d;
      pend_q      <= pend_d;
      pend_last_q <= pend_last_d;
      out_q       <= out_d;
      valid_q     <= valid_d;
      frame_ok_q  <= frame_ok_d;
      err_chk_q   <= err_chk_d;
      err_len_q   <= err_len_d;
      err_to_q    <= err_to_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  assign pl.o_pl_data   = out_q.data;
  assign pl.o_pl_valid  = valid_q;
  assign pl.o_pl_last   = out_q.last;
  assign o_frame_ok     = frame_ok_q;
  assign o_err_chk      = err_chk_q;
  assign o_err_len      = err_len_q;
  assign o_err_timeout  = err_to_q;
  assign o_overrun      = overrun_q;
  assign o_busy         = busy_q;

endmodule
